// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: PC register, instruction-memory address and
// the IF/ID pipeline register, with branch redirect, stall and fetch counter.
module fetch_unit #(
  parameter int               WORD     = 64,
  parameter int               INSTR    = 32,
  parameter logic [WORD-1:0]  RESET_PC = '0,
  parameter logic [INSTR-1:0] NOP      = 32'hD503201F
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_pc_src,
  input  logic [WORD-1:0]  i_branch_target,
  input  logic [INSTR-1:0] i_imem_data,
  output logic [WORD-1:0]  o_imem_addr,
  output logic [WORD-1:0]  o_if_id_pc,
  output logic [WORD-1:0]  o_if_id_pc_plus4,
  output logic [INSTR-1:0] o_if_id_instr,
  output logic             o_if_id_valid,
  output logic [31:0]      o_fetch_count
);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_FLUSH} state_t;

  typedef struct packed {
    logic [WORD-1:0]  pc;
    logic [WORD-1:0]  pc4;
    logic [INSTR-1:0] instr;
    logic             valid;
  } ifid_t;

  localparam logic [WORD-1:0] ALIGN_MASK = {{(WORD-2){1'b1}}, 2'b00};

  state_t          r_state;
  logic [WORD-1:0] r_pc;
  ifid_t           r_ifid;
  logic [31:0]     r_count;

  logic [WORD-1:0] w_pc_plus4;
  logic [WORD-1:0] w_target;

  assign w_pc_plus4 = r_pc + WORD'(4);
  assign w_target   = i_branch_target & ALIGN_MASK;

  // RUN and FLUSH share the same per-edge rules; FLUSH only marks the
  // cycle following a redirect so the bubble is observable as a state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_RESET;
      r_pc         <= RESET_PC;
      r_ifid.pc    <= '0;
      r_ifid.pc4   <= '0;
      r_ifid.instr <= NOP;
      r_ifid.valid <= 1'b0;
      r_count      <= '0;
    end else begin
      case (r_state)
        S_RESET: r_state <= S_RUN;
        S_RUN, S_FLUSH: begin
          if (i_pc_src) begin
            r_pc         <= w_target;
            r_ifid.instr <= NOP;
            r_ifid.valid <= 1'b0;
            r_state      <= S_FLUSH;
          end else begin
            r_state <= S_RUN;
            if (!i_stall) begin
              r_ifid.pc    <= r_pc;
              r_ifid.pc4   <= w_pc_plus4;
              r_ifid.instr <= i_imem_data;
              r_ifid.valid <= 1'b1;
              r_pc         <= w_pc_plus4;
              if (r_count != 32'hFFFF_FFFF) r_count <= r_count + 32'd1;
            end
          end
        end
        default: r_state <= S_RESET;
      endcase
    end
  end

  assign o_imem_addr      = r_pc;
  assign o_if_id_pc       = r_ifid.pc;
  assign o_if_id_pc_plus4 = r_ifid.pc4;
  assign o_if_id_instr    = r_ifid.instr;
  assign o_if_id_valid    = r_ifid.valid;
  assign o_fetch_count    = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vectors, a behavioural fetch model checked
// every negative edge, and literal expectations at the key points.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        pc_src = 1'b0;
  logic [63:0] bt = '0;
  logic [31:0] imem_data;
  logic [63:0] imem_addr, if_id_pc, if_id_pc4;
  logic [31:0] if_id_instr, fetch_count;
  logic        if_id_valid;

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_pc_src(pc_src),
    .i_branch_target(bt), .i_imem_data(imem_data),
    .o_imem_addr(imem_addr), .o_if_id_pc(if_id_pc),
    .o_if_id_pc_plus4(if_id_pc4), .o_if_id_instr(if_id_instr),
    .o_if_id_valid(if_id_valid), .o_fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h8B020020;
      64'd4:   return 32'hCB020020;
      default: return 32'hA000_0000 ^ a[31:0];
    endcase
  endfunction

  assign imem_data = mem_f(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural PC plus the last delivered instruction.
  logic [63:0] m_pc, m_ifpc, m_ifpc4;
  logic [31:0] m_instr, m_count;
  logic        m_valid, m_run, m_init = 1'b0;

  task automatic model_reset();
    m_pc = 64'd0; m_ifpc = 64'd0; m_ifpc4 = 64'd0;
    m_instr = NOP; m_valid = 1'b0; m_count = 32'd0; m_run = 1'b0; m_init = 1'b1;
  endtask

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    if (!rst && m_init) begin
      if (!m_run) m_run = 1'b1;
      else if (pc_src) begin
        m_pc = {bt[63:2], 2'b00};
        m_instr = NOP;
        m_valid = 1'b0;
      end else if (!stall) begin
        m_ifpc  = m_pc;
        m_ifpc4 = m_pc + 64'd4;
        m_instr = mem_f(m_pc);
        m_valid = 1'b1;
        m_pc    = m_pc + 64'd4;
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_addr",  imem_addr,   m_pc);
      chk("m_pc",    if_id_pc,    m_ifpc);
      chk("m_pc4",   if_id_pc4,   m_ifpc4);
      chk("m_instr", {32'd0, if_id_instr}, {32'd0, m_instr});
      chk("m_valid", {63'd0, if_id_valid}, {63'd0, m_valid});
      chk("m_count", {32'd0, fetch_count}, {32'd0, m_count});
    end
  end

  task automatic cyc(input logic s, input logic p, input logic [63:0] b);
    stall = s; pc_src = p; bt = b;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_addr",  imem_addr, 64'd0);
    chk("rst_valid", {63'd0, if_id_valid}, 64'd0);
    chk("rst_instr", {32'd0, if_id_instr}, {32'd0, NOP});
    chk("rst_count", {32'd0, fetch_count}, 64'd0);
    rst = 1'b0;
    cyc(0, 0, 0);
    chk("rel_valid", {63'd0, if_id_valid}, 64'd0);
    chk("rel_addr",  imem_addr, 64'd0);

    cyc(0, 0, 0);
    chk("seq0_pc",    if_id_pc, 64'd0);
    chk("seq0_instr", {32'd0, if_id_instr}, 64'h8B020020);
    cyc(0, 0, 0);
    chk("seq1_pc",    if_id_pc, 64'd4);
    chk("seq1_instr", {32'd0, if_id_instr}, 64'hCB020020);
    chk("seq1_addr",  imem_addr, 64'd8);
    chk("seq1_count", {32'd0, fetch_count}, 64'd2);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      chk("stl_addr",  imem_addr, 64'd8);
      chk("stl_pc",    if_id_pc, 64'd4);
      chk("stl_count", {32'd0, fetch_count}, 64'd2);
    end
    cyc(0, 0, 0);
    chk("unstl_pc", if_id_pc, 64'd8);

    cyc(1, 1, 64'd67);
    chk("br_addr",  imem_addr, 64'd64);
    chk("br_valid", {63'd0, if_id_valid}, 64'd0);
    chk("br_instr", {32'd0, if_id_instr}, {32'd0, NOP});
    cyc(0, 0, 0);
    chk("br_pc",    if_id_pc, 64'd64);
    chk("br_vld1",  {63'd0, if_id_valid}, 64'd1);
    chk("br_count", {32'd0, fetch_count}, 64'd4);

    cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(0, 0, 0);
    chk("wr_pc",   if_id_pc,  64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_pc4",  if_id_pc4, 64'd0);
    chk("wr_addr", imem_addr, 64'd0);

    cyc(0, 1, 64'h100);
    cyc(1, 1, 64'h203);
    chk("b2b_addr", imem_addr, 64'h200);
    chk("b2b_vld",  {63'd0, if_id_valid}, 64'd0);
    cyc(0, 0, 0);
    chk("b2b_pc",   if_id_pc, 64'h200);
    cyc(0, 0, 0);
    cyc(1, 0, 0);

    cyc(0, 1, 64'h40);
    pc_src = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("ar_addr",  imem_addr, 64'd0);
    chk("ar_pc",    if_id_pc, 64'd0);
    chk("ar_pc4",   if_id_pc4, 64'd0);
    chk("ar_instr", {32'd0, if_id_instr}, {32'd0, NOP});
    chk("ar_valid", {63'd0, if_id_valid}, 64'd0);
    chk("ar_count", {32'd0, fetch_count}, 64'd0);
    cyc(1, 1, 64'h80);
    rst = 1'b0;
    cyc(0, 1, 64'h80);
    chk("ar_rel_addr", imem_addr, 64'd0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("ar_run_pc",    if_id_pc, 64'd4);
    chk("ar_run_count", {32'd0, fetch_count}, 64'd2);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the LEGv8 datapath. Holds the PC, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register.
- Consumes pc_src and the branch target resolved by the memory stage to redirect fetch. A taken redirect squashes the in-flight fetch, and a stall freezes the stage.
- Keeps a saturating count of valid instructions delivered, for performance checks.

Parameters:
- WORD, 64, datapath / PC width in bits.
- INSTR, 32, instruction width in bits.
- RESET_PC, 0, PC value loaded on reset.
- NOP, 32'hD503201F, LEGv8 NOP encoding inserted on bubbles.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds PC and IF/ID.
- pc_src  in  1  branch-taken select from the memory stage.
- branch_target  in  WORD  redirect address from the memory stage.
- imem_data  in  INSTR  instruction word returned combinationally for imem_addr.
- imem_addr  out  WORD  current PC; combinational from the PC register.
- if_id_pc  out  WORD  PC of the registered instruction.
- if_id_pc_plus4  out  WORD  if_id_pc + 4.
- if_id_instr  out  INSTR  registered instruction.
- if_id_valid  out  1  1 = if_id_instr is a real instruction; 0 = bubble.
- fetch_count  out  32  number of valid instructions latched into IF/ID; saturates.

Behaviour:
- States: RESET, RUN, FLUSH.
  - rst asserted: go to RESET asynchronously.
  - First rising edge with rst low: RESET -> RUN. No fetch is latched on that edge; PC is held.
- Reset values, applied immediately when rst rises:
  - pc = RESET_PC, imem_addr = RESET_PC.
  - if_id_pc = 0, if_id_pc_plus4 = 0.
  - if_id_instr = NOP, if_id_valid = 0.
  - fetch_count = 0.
- RUN, per rising edge, in priority order:
  1. pc_src=1, regardless of stall: pc <= {branch_target[WORD-1:2], 2'b00}; IF/ID <= bubble (instr=NOP, valid=0, pc fields hold). Go to FLUSH.
  2. stall=1: pc and all IF/ID fields hold; fetch_count holds.
  3. Otherwise: if_id_pc <= pc; if_id_pc_plus4 <= pc+4; if_id_instr <= imem_data; if_id_valid <= 1; pc <= pc+4; fetch_count += 1.
- FLUSH lasts one cycle. Apply the RUN rules for that edge, then go to RUN. A back-to-back pc_src re-enters FLUSH.
- Latency: instruction at PC X appears on IF/ID one edge after imem_addr = X with stall low.
- Redirect penalty: exactly one bubble.
- Arithmetic: pc+4 wraps modulo 2^WORD, so 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Redirect alignment: branch_target[1:0] is always cleared.
- fetch_count saturates at 32'hFFFF_FFFF.
- Reset mid-stall or mid-redirect: reset wins; all state returns to reset values with no partial update.
- No X propagation: outputs are defined from reset onward.

Test Plan:
1. Assert rst for 2 cycles, then release.
   - During reset: imem_addr=0, if_id_valid=0, if_id_instr=NOP, fetch_count=0.
   - First edge after release: still valid=0.
2. Sequential fetch, imem_data = 32'h8B020020 then 32'hCB020020.
   - After 2 edges: if_id_pc=0, then 4; instr matches each in turn; imem_addr=8; fetch_count=2.
3. stall=1 for 3 cycles with PC=8.
   - imem_addr stays 8; IF/ID unchanged; fetch_count unchanged.
   - Release stall: if_id_pc=8.
4. Redirect: pc_src=1, branch_target=64'd67, stall=1 on the same edge.
   - imem_addr=64; if_id_valid=0; if_id_instr=NOP.
   - Next edge: if_id_pc=64, valid=1.
5. Wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC, then one normal edge.
   - if_id_pc=...FFFC, if_id_pc_plus4=0, imem_addr=0.
6. Assert rst asynchronously between edges during FLUSH.
   - Outputs return to reset values before the next clock edge.
